// File: rtl/dfg_pipe_alu_pkg.sv
// Shared types for the handshaked ALU: opcodes, FSM states, response flags.
package dfg_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_MUL     = 4'd2,
        OP_AND     = 4'd3,
        OP_OR      = 4'd4,
        OP_XOR     = 4'd5,
        OP_SHL     = 4'd6,
        OP_SHR     = 4'd7,
        OP_SHRA    = 4'd8,
        OP_EQ      = 4'd9,
        OP_LT      = 4'd10,
        OP_RED_OR  = 4'd11,
        OP_RED_AND = 4'd12,
        OP_RED_XOR = 4'd13,
        OP_DIV     = 4'd14,
        OP_MOD     = 4'd15
    } alu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic dbz;
    } rsp_flags_t;

    function automatic logic is_div_op(alu_op_e op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/dfg_pipe_alu_if.sv
// Request/response handshake bundle between producer, ALU and consumer.
interface dfg_pipe_alu_if
    import dfg_alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_req_valid;
    logic             out_req_ready;
    alu_op_e          in_req_op;
    logic             in_req_signed;
    logic [WIDTH-1:0] in_req_a;
    logic [WIDTH-1:0] in_req_b;
    logic             out_rsp_valid;
    logic             in_rsp_ready;
    logic [WIDTH-1:0] out_rsp_data;
    logic             out_rsp_zero;
    logic             out_rsp_dbz;
    logic             out_busy;

    modport master (
        output in_req_valid, in_req_op, in_req_signed,
        output in_req_a, in_req_b, in_rsp_ready,
        input  out_req_ready, out_rsp_valid, out_rsp_data,
        input  out_rsp_zero, out_rsp_dbz, out_busy
    );

    modport slave (
        input  in_req_valid, in_req_op, in_req_signed,
        input  in_req_a, in_req_b, in_rsp_ready,
        output out_req_ready, out_rsp_valid, out_rsp_data,
        output out_rsp_zero, out_rsp_dbz, out_busy
    );
endinterface

// File: rtl/dfg_pipe_alu_divider.sv
// Restoring divider, one quotient bit per clock; signs stripped on start, restored on the last step.
module dfg_alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] mag(logic s, logic [WIDTH-1:0] x);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH-1:0] a_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_comb begin
        trial  = {rem_q, quo_q[WIDTH-1]};
        diff   = trial - {1'b0, bmag};
        qbit   = ~diff[WIDTH];
        rem_nx = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], qbit};
    end

    // Final step result goes straight out so the top can load it on the same edge.
    assign done = run && (cnt == LAST);
    assign dbz  = dbz_q;
    assign quo  = dbz_q ? '1    : (neg_q ? -quo_nx : quo_nx);
    assign rem  = dbz_q ? a_raw : (neg_r ? -rem_nx : rem_nx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            bmag  <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz_q <= 1'b0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= mag(sgn, a);
            bmag  <= mag(sgn, b);
            a_raw <= a;
            neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn && a[WIDTH-1];
            dbz_q <= (b == '0);
        end else if (run) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) run <= 1'b0;
        end
    end
endmodule

// File: rtl/dfg_pipe_alu.sv
// Handshaked ALU with one-entry result register and optional iterative divider.
// DFG_ALU_DIV_EN enables the divider; otherwise DIV/MOD return 0 with dbz set.
module dfg_pipe_alu
    import dfg_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input logic           in_clk,
    input logic           in_rst_n,
    dfg_pipe_alu_if.slave bus
);
    localparam logic [SHAMT_W-1:0] SH_LIM = SHAMT_W'(WIDTH);

    alu_state_e       state;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    rsp_flags_t       flags;

    logic             req_ready;
    logic             accept;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic [SHAMT_W-1:0] sh;
    logic             fill;
    logic [WIDTH:0]   sra_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_dbz;

    assign a   = bus.in_req_a;
    assign b   = bus.in_req_b;
    assign sgn = bus.in_req_signed;
    assign sh  = b[SHAMT_W-1:0];

    assign req_ready = (state == S_IDLE) && (!rsp_valid || bus.in_rsp_ready);
    assign accept    = bus.in_req_valid && req_ready;

    assign bus.out_req_ready = req_ready;
    assign bus.out_rsp_valid = rsp_valid;
    assign bus.out_rsp_data  = rsp_data;
    assign bus.out_rsp_zero  = flags.zero;
    assign bus.out_rsp_dbz   = flags.dbz;

    always_comb begin
        alu_res = '0;
        alu_dbz = 1'b0;
        fill    = sgn && a[WIDTH-1];
        sra_ext = $signed({fill, a}) >>> sh;
        unique case (bus.in_req_op)
            OP_ADD:     alu_res = a + b;
            OP_SUB:     alu_res = a - b;
            OP_MUL:     alu_res = a * b;
            OP_AND:     alu_res = a & b;
            OP_OR:      alu_res = a | b;
            OP_XOR:     alu_res = a ^ b;
            OP_SHL:     alu_res = (sh >= SH_LIM) ? '0 : (a << sh);
            OP_SHR:     alu_res = (sh >= SH_LIM) ? '0 : (a >> sh);
            OP_SHRA:    alu_res = (sh >= SH_LIM) ? {WIDTH{fill}}
                                                 : sra_ext[WIDTH-1:0];
            OP_EQ:      alu_res = WIDTH'(a == b);
            OP_LT:      alu_res = sgn ? WIDTH'($signed(a) < $signed(b))
                                      : WIDTH'(a < b);
            OP_RED_OR:  alu_res = WIDTH'(|a);
            OP_RED_AND: alu_res = WIDTH'(&a);
            OP_RED_XOR: alu_res = WIDTH'(^a);
            OP_DIV,
            OP_MOD: begin
`ifdef DFG_ALU_DIV_EN
                alu_dbz = 1'b0;
`else
                alu_dbz = 1'b1;
`endif
            end
            default:    alu_res = '0;
        endcase
    end

`ifdef DFG_ALU_DIV_EN
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_dbz;
    logic             mod_sel;
    logic [WIDTH-1:0] div_res;

    assign div_start = accept && is_div_op(bus.in_req_op);
    assign div_res   = mod_sel ? div_rem : div_quo;
    assign bus.out_busy = (state == S_DIV);

    dfg_alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .start (div_start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .done  (div_done),
        .quo   (div_quo),
        .rem   (div_rem),
        .dbz   (div_dbz)
    );
`else
    assign bus.out_busy = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            flags     <= '0;
`ifdef DFG_ALU_DIV_EN
            mod_sel   <= 1'b0;
`endif
        end else begin
            if (rsp_valid && bus.in_rsp_ready) rsp_valid <= 1'b0;
`ifdef DFG_ALU_DIV_EN
            if (accept && is_div_op(bus.in_req_op)) begin
                state   <= S_DIV;
                mod_sel <= (bus.in_req_op == OP_MOD);
            end else if (accept) begin
                rsp_valid  <= 1'b1;
                rsp_data   <= alu_res;
                flags.zero <= (alu_res == '0);
                flags.dbz  <= alu_dbz;
            end
            if (state == S_DIV && div_done) begin
                state      <= S_IDLE;
                rsp_valid  <= 1'b1;
                rsp_data   <= div_res;
                flags.zero <= (div_res == '0);
                flags.dbz  <= div_dbz;
            end
`else
            if (accept) begin
                rsp_valid  <= 1'b1;
                rsp_data   <= alu_res;
                flags.zero <= (alu_res == '0);
                flags.dbz  <= alu_dbz;
            end
`endif
        end
    end
endmodule

// File: tb/tb_dfg_pipe_alu.sv
// Scoreboard bench for dfg_pipe_alu: directed cases, stall/back-to-back, reset mid-op, random.
module tb_dfg_pipe_alu;
    import dfg_alu_pkg::*;

    localparam int W  = 8;
    localparam int SW = $clog2(W) + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         zero;
        logic         dbz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    dfg_pipe_alu_if #(.WIDTH(W)) bus ();

    dfg_pipe_alu #(.WIDTH(W)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(alu_op_e op, logic s, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb_, ia, sh, r;
        logic dz;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
        ia  = s ? sa : ua;
        sh  = int'(b[SW-1:0]);
        dz  = 1'b0;
        r   = 0;
        case (op)
            OP_ADD:     r = ua + ub;
            OP_SUB:     r = ua - ub;
            OP_MUL:     r = ua * ub;
            OP_AND:     r = ua & ub;
            OP_OR:      r = ua | ub;
            OP_XOR:     r = ua ^ ub;
            OP_SHL:     r = (sh >= W) ? 0 : (ua << sh);
            OP_SHR:     r = (sh >= W) ? 0 : (ua >> sh);
            OP_SHRA:    r = ia >>> sh;
            OP_EQ:      r = (ua == ub) ? 1 : 0;
            OP_LT:      r = s ? ((sa < sb_) ? 1 : 0) : ((ua < ub) ? 1 : 0);
            OP_RED_OR:  r = (ua != 0) ? 1 : 0;
            OP_RED_AND: r = (ua == (1 << W) - 1) ? 1 : 0;
            OP_RED_XOR: r = int'($countones(a)) % 2;
`ifdef DFG_ALU_DIV_EN
            OP_DIV: begin
                if (ub == 0) begin r = -1; dz = 1'b1; end
                else r = s ? sa / sb_ : ua / ub;
            end
            OP_MOD: begin
                if (ub == 0) begin r = ua; dz = 1'b1; end
                else r = s ? sa % sb_ : ua % ub;
            end
`else
            OP_DIV, OP_MOD: begin r = 0; dz = 1'b1; end
`endif
            default: r = 0;
        endcase
        e.data = r[W-1:0];
        e.zero = (e.data == '0);
        e.dbz  = dz;
        return e;
    endfunction

    // Response side of the scoreboard: handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_rsp_valid && bus.in_rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.out_rsp_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", 32'(bus.out_rsp_data), 32'(e.data));
                chk("rsp_zero", 32'(bus.out_rsp_zero), 32'(e.zero));
                chk("rsp_dbz",  32'(bus.out_rsp_dbz),  32'(e.dbz));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(alu_op_e op, logic s, logic [W-1:0] a, logic [W-1:0] b,
                        output int acc_cyc);
        int n;
        bus.in_req_valid  = 1'b1;
        bus.in_req_op     = op;
        bus.in_req_signed = s;
        bus.in_req_a      = a;
        bus.in_req_b      = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.out_req_ready) break;
            n++;
            if (n > 200) begin
                chk("req_timeout", 32'(bus.out_req_ready), 1);
                break;
            end
        end
        if (bus.out_req_ready) sb.push_back(model(op, s, a, b));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.in_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    bit rand_done;

    initial begin
        int c0, c1, c2, k, bc;
        rst_n             = 1'b0;
        bus.in_req_valid  = 1'b0;
        bus.in_req_op     = OP_ADD;
        bus.in_req_signed = 1'b0;
        bus.in_req_a      = '0;
        bus.in_req_b      = '0;
        bus.in_rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_rsp_valid), 0);
        chk("rst_data",  32'(bus.out_rsp_data), 0);
        chk("rst_zero",  32'(bus.out_rsp_zero), 0);
        chk("rst_dbz",   32'(bus.out_rsp_dbz), 0);
        chk("rst_busy",  32'(bus.out_busy), 0);
        chk("rst_ready", 32'(bus.out_req_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases; latency of ADD checked explicitly.
        send(OP_ADD, 1'b0, 8'hF0, 8'h20, c0);
        @(negedge clk);
        chk("add_lat_valid", 32'(bus.out_rsp_valid), 1);
        chk("add_data", 32'(bus.out_rsp_data), 32'h10);
        chk("add_zero", 32'(bus.out_rsp_zero), 0);
        @(posedge clk);
        #1;
        send(OP_SHRA, 1'b1, 8'h80, 8'd9, c0);
        send(OP_SHR,  1'b1, 8'h80, 8'd9, c0);
        send(OP_SHRA, 1'b0, 8'h80, 8'd9, c0);
        send(OP_SHL,  1'b0, 8'h01, 8'd3, c0);
        send(OP_SHRA, 1'b1, 8'h90, 8'd2, c0);
        send(OP_SUB,  1'b0, 8'h05, 8'h05, c0);
        send(OP_LT,   1'b1, 8'hFF, 8'h01, c0);
        send(OP_LT,   1'b0, 8'hFF, 8'h01, c0);
        wait_drain();

        // Divider latency and busy window.
        send(OP_DIV, 1'b1, 8'hF9, 8'h02, c0);
        k = 0;
        bc = 0;
        do begin
            @(negedge clk);
            if (bus.out_busy) bc++;
            k++;
        end while (!bus.out_rsp_valid && k < 50);
`ifdef DFG_ALU_DIV_EN
        chk("div_latency", 32'(k), W + 1);
        chk("div_busy_cycles", 32'(bc), W);
`else
        chk("div_latency", 32'(k), 1);
        chk("div_busy_cycles", 32'(bc), 0);
`endif
        @(posedge clk);
        #1;
        send(OP_MOD, 1'b1, 8'hF9, 8'h02, c0);
        send(OP_DIV, 1'b0, 8'd5, 8'd0, c0);
        send(OP_MOD, 1'b0, 8'd5, 8'd0, c0);
        send(OP_DIV, 1'b1, 8'h80, 8'hFF, c0);
        send(OP_MOD, 1'b1, 8'h80, 8'hFF, c0);
        send(OP_DIV, 1'b0, 8'd200, 8'd7, c0);
        wait_drain();

        // Consumer stall holds the result and blocks new requests.
        bus.in_rsp_ready = 1'b0;
        send(OP_XOR, 1'b0, 8'h5A, 8'h0F, c0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_rsp_valid), 1);
            chk("stall_data", 32'(bus.out_rsp_data), 32'h55);
            chk("stall_req_ready", 32'(bus.out_req_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.in_rsp_ready = 1'b1;
        send(OP_ADD, 1'b0, 8'd1, 8'd2, c0);
        send(OP_MUL, 1'b0, 8'd13, 8'd11, c1);
        send(OP_AND, 1'b0, 8'hCC, 8'hAA, c2);
        chk("b2b_gap1", 32'(c1 - c0), 1);
        chk("b2b_gap2", 32'(c2 - c1), 1);
        wait_drain();

        // Reset in the middle of a division abandons it.
        bus.in_rsp_ready = 1'b0;
        send(OP_DIV, 1'b0, 8'd100, 8'd3, c0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_rsp_valid), 0);
        chk("midrst_busy", 32'(bus.out_busy), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_rsp_ready = 1'b1;
        send(OP_ADD, 1'b0, 8'd3, 8'd4, c0);
        wait_drain();

        // Random traffic with random consumer back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [W-1:0] ra, rb;
                    alu_op_e rop;
                    rop = alu_op_e'($urandom_range(0, 15));
                    ra  = ($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom);
                    rb  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 12))
                                                      : W'($urandom);
                    send(rop, 1'($urandom_range(0, 1)), ra, rb, c0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.in_rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.in_rsp_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
